// File: rtl/riscv_trace_capture_pkg.sv
`default_nettype none
// ============================================================================
// riscv_trace_capture_pkg
//   Shared types for the trace capture buffer: FSM states, filter codes,
//   entry layout.
//   Revision: 1.0
// ============================================================================
package riscv_trace_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] FILT_ALL  = 2'd0;
    localparam logic [1:0] FILT_CTRL = 2'd1;
    localparam logic [1:0] FILT_TRAP = 2'd2;
    localparam logic [1:0] FILT_ALL3 = 2'd3;

    localparam int ENTRY_BITS    = 40;
    localparam int ENT_PC_LSB    = 0;
    localparam int ENT_MODE_LSB  = 32;
    localparam int ENT_TAKEN_BIT = 35;
    localparam int ENT_TRAP_BIT  = 36;
    localparam int ENT_RET_BIT   = 37;
    localparam int ENT_JALR_BIT  = 38;
    localparam int ENT_BKPT_BIT  = 39;

    // Declared MSB first so the packed layout matches the bit offsets above.
    typedef struct packed {
        logic        bkpt;
        logic        jalr;
        logic        ret;
        logic        trap;
        logic        taken;
        logic [2:0]  mode;
        logic [31:0] pc;
    } entry_t;

    function automatic logic filter_pass(input logic [1:0] filt,
                                         input logic taken, input logic jalr,
                                         input logic ret, input logic trap,
                                         input logic bkpt);
        case (filt)
            FILT_CTRL: return taken | jalr | ret | trap;
            FILT_TRAP: return trap | bkpt;
            default:   return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_trace_capture_if.sv
`default_nettype none
// ============================================================================
// riscv_trace_capture_if
//   Valid/ready readout port of the trace capture buffer.
//   Revision: 1.0
// ============================================================================
interface riscv_trace_capture_if;
    import riscv_trace_capture_pkg::*;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [ENTRY_BITS-1:0] rd_data;
    logic                  rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface
`default_nettype wire

// File: rtl/riscv_trace_capture_ram.sv
`default_nettype none
// ============================================================================
// trace_capture_ram
//   Register array, one synchronous write port, one asynchronous read port.
//   Revision: 1.0
// ============================================================================
module trace_capture_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 40
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule
`default_nettype wire

// File: rtl/riscv_trace_capture.sv
`default_nettype none
// ============================================================================
// riscv_trace_capture
//   Filtered retirement recorder with pre/post trigger freeze and readout.
//   Revision: 1.0
// ============================================================================
module riscv_trace_capture
    import riscv_trace_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int ENTRY_W    = 40
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  trace__instr_valid,
    input  wire logic [31:0]           trace__instr_pc,
    input  wire logic [2:0]            trace__mode,
    input  wire logic                  trace__branch_taken,
    input  wire logic                  trace__jalr,
    input  wire logic                  trace__ret,
    input  wire logic                  trace__trap,
    input  wire logic                  trace__bkpt_valid,
    input  wire logic [1:0]            cfg_filter,
    input  wire logic [DEPTH_LOG2:0]   cfg_post_count,
    input  wire logic [31:0]           cfg_trigger_pc,
    input  wire logic                  cfg_trigger_pc_en,
    input  wire logic                  arm,
    input  wire logic                  ext_trigger,
    riscv_trace_capture_if.master      rd,
    output logic [1:0]                 status_state,
    output logic [DEPTH_LOG2:0]        status_count,
    output logic                       status_wrapped
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
    localparam cnt_t POST_MAX = cnt_t'(DEPTH - 1);

    state_e state_q, state_d;
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    ptr_t   post_q, post_d;
    cnt_t   count_q, count_d;
    logic   wrapped_q, wrapped_d;

    entry_t               new_entry;
    logic [ENTRY_W-1:0]   ram_rdata;
    cnt_t                 post_load;
    logic                 trig;
    logic                 filt_ok;
    logic                 capture;
    logic                 rd_valid;
    logic                 rd_last;
    logic                 xfer;

    always_comb begin
        new_entry.pc    = trace__instr_pc;
        new_entry.mode  = trace__mode;
        new_entry.taken = trace__branch_taken;
        new_entry.trap  = trace__trap;
        new_entry.ret   = trace__ret;
        new_entry.jalr  = trace__jalr;
        new_entry.bkpt  = trace__bkpt_valid;
    end

    assign trig = ext_trigger
                | (trace__instr_valid & trace__bkpt_valid)
                | (trace__instr_valid & cfg_trigger_pc_en & (trace__instr_pc == cfg_trigger_pc));
    assign filt_ok   = filter_pass(cfg_filter, trace__branch_taken, trace__jalr,
                                   trace__ret, trace__trap, trace__bkpt_valid);
    assign post_load = (cfg_post_count > POST_MAX) ? POST_MAX : cfg_post_count;
    assign rd_valid  = (state_q == ST_DONE) && (count_q != '0);
    assign rd_last   = rd_valid && (count_q == cnt_t'(1));
    assign xfer      = rd_valid && rd.rd_ready;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        post_d    = post_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        capture   = 1'b0;

        if (arm) begin
            state_d   = ST_PRE;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
            post_d    = '0;
        end else begin
            case (state_q)
                ST_PRE: begin
                    // The trigger retirement is kept even if the filter rejects it.
                    capture = trace__instr_valid & (filt_ok | trig);
                    if (trig) begin
                        post_d  = post_load[DEPTH_LOG2-1:0];
                        state_d = (post_load == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    capture = trace__instr_valid & filt_ok;
                    if (capture) begin
                        post_d = post_q - ptr_t'(1);
                        if (post_q == ptr_t'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (count_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (xfer) begin
                        rd_ptr_d = rd_ptr_q + ptr_t'(1);
                        count_d  = count_q - cnt_t'(1);
                        if (rd_last) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase

            if (capture) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
                if (count_q == DEPTH_C) begin
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + cnt_t'(1);
                end
            end

            // A full buffer truncates to zero, which correctly points at wr_ptr.
            if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
                rd_ptr_d = wr_ptr_d - ptr_t'(count_d);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            post_q    <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            post_q    <= post_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    trace_capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr_q),
        .wdata (new_entry),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign rd.rd_valid     = rd_valid;
    assign rd.rd_last      = rd_last;
    assign rd.rd_data      = ram_rdata;
    assign status_state   = state_q;
    assign status_count   = count_q;
    assign status_wrapped = wrapped_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_trace_capture.sv
`default_nettype none
// ============================================================================
// tb_riscv_trace_capture
//   Randomised bench against a queue-based capture model; DEPTH 64 and 8.
//   Revision: 1.0
// ============================================================================
module tb_riscv_trace_capture;
    import riscv_trace_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iv, taken, jalr, ret, trap, bkpt, ext, tpc_en, arm64, arm8;
    logic [31:0] pc, tpc;
    logic [2:0]  mode;
    logic [1:0]  filt;
    logic [6:0]  post64;
    logic [3:0]  post8;
    logic [1:0]  st64, st8;
    logic [6:0]  cnt64;
    logic [3:0]  cnt8;
    logic        wr64, wr8;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: everything recorded since arm, in order.
    bit          sel8 = 1'b0;
    int          m_depth = 64;
    int          m_phase = 0;
    int          m_left = 0;
    logic [39:0] m_q[$];

    always #5 clk = ~clk;

    riscv_trace_capture_if if64 ();
    riscv_trace_capture_if if8 ();

    riscv_trace_capture #(.DEPTH_LOG2(6), .ENTRY_W(40)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .trace__instr_valid(iv), .trace__instr_pc(pc), .trace__mode(mode),
        .trace__branch_taken(taken), .trace__jalr(jalr), .trace__ret(ret),
        .trace__trap(trap), .trace__bkpt_valid(bkpt),
        .cfg_filter(filt), .cfg_post_count(post64), .cfg_trigger_pc(tpc),
        .cfg_trigger_pc_en(tpc_en), .arm(arm64), .ext_trigger(ext),
        .rd(if64), .status_state(st64), .status_count(cnt64), .status_wrapped(wr64)
    );

    riscv_trace_capture #(.DEPTH_LOG2(3), .ENTRY_W(40)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .trace__instr_valid(iv), .trace__instr_pc(pc), .trace__mode(mode),
        .trace__branch_taken(taken), .trace__jalr(jalr), .trace__ret(ret),
        .trace__trap(trap), .trace__bkpt_valid(bkpt),
        .cfg_filter(filt), .cfg_post_count(post8), .cfg_trigger_pc(tpc),
        .cfg_trigger_pc_en(tpc_en), .arm(arm8), .ext_trigger(ext),
        .rd(if8), .status_state(st8), .status_count(cnt8), .status_wrapped(wr8)
    );

    function automatic logic [1:0]  cur_state();   return sel8 ? st8 : st64;              endfunction
    function automatic logic [6:0]  cur_count();   return sel8 ? {3'b000, cnt8} : cnt64;  endfunction
    function automatic logic        cur_wrapped(); return sel8 ? wr8 : wr64;              endfunction
    function automatic logic        cur_valid();   return sel8 ? if8.rd_valid : if64.rd_valid; endfunction
    function automatic logic        cur_last();    return sel8 ? if8.rd_last : if64.rd_last;   endfunction
    function automatic logic [39:0] cur_data();    return sel8 ? if8.rd_data : if64.rd_data;   endfunction

    task automatic set_ready(input logic v);
        if (sel8) if8.rd_ready = v;
        else      if64.rd_ready = v;
    endtask

    // Apply the model for the current inputs, then advance one clock.
    task automatic tick();
        logic [39:0] e;
        logic        tr, pass, arm_now;
        int          pcfg;
        e       = {bkpt, jalr, ret, trap, taken, mode, pc};
        tr      = ext | (iv & bkpt) | (iv & tpc_en & (pc == tpc));
        pass    = (filt == 2'd1) ? (taken | jalr | ret | trap) :
                  (filt == 2'd2) ? (trap | bkpt) : 1'b1;
        arm_now = sel8 ? arm8 : arm64;
        pcfg    = sel8 ? int'(post8) : int'(post64);
        if (arm_now) begin
            m_q.delete();
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (iv && (pass || tr)) m_q.push_back(e);
            if (tr) begin
                m_left  = (pcfg > m_depth - 1) ? m_depth - 1 : pcfg;
                m_phase = (m_left == 0) ? 3 : 2;
            end
        end else if (m_phase == 2) begin
            if (iv && pass) begin
                m_q.push_back(e);
                m_left--;
                if (m_left == 0) m_phase = 3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] p, input bit t_ext, input bit bk, input bit plain);
        iv    = 1'b1;
        pc    = p;
        mode  = 3'($urandom);
        taken = plain ? 1'b0 : ($urandom_range(3) == 0);
        jalr  = plain ? 1'b0 : ($urandom_range(3) == 0);
        ret   = plain ? 1'b0 : ($urandom_range(3) == 0);
        trap  = plain ? 1'b0 : ($urandom_range(3) == 0);
        bkpt  = bk;
        ext   = t_ext;
        tick();
        iv   = 1'b0;
        ext  = 1'b0;
        bkpt = 1'b0;
        if ($urandom_range(3) == 0) tick();
    endtask

    task automatic do_arm();
        if (sel8) arm8 = 1'b1;
        else      arm64 = 1'b1;
        tick();
        arm8  = 1'b0;
        arm64 = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        return {$urandom} & 32'hFFFF_FFFC;
    endfunction

    // Drain the selected DUT and compare every entry against the model.
    task automatic drain(input string name, input bit toggle);
        logic [39:0] exp[$];
        int n, idx, budget;
        logic r;
        n = (m_q.size() > m_depth) ? m_depth : m_q.size();
        for (int i = 0; i < n; i++) exp.push_back(m_q[m_q.size() - n + i]);
        vectors++;
        if (cur_state() !== 2'd3) begin
            miscompares++;
            $display("FAIL %s done_state: got %0d want 3", name, cur_state());
        end
        vectors++;
        if (cur_count() !== 7'(n)) begin
            miscompares++;
            $display("FAIL %s done_count: got %0d want %0d", name, cur_count(), n);
        end
        vectors++;
        if (cur_wrapped() !== (m_q.size() > m_depth)) begin
            miscompares++;
            $display("FAIL %s wrapped: got %0b want %0b", name, cur_wrapped(), m_q.size() > m_depth);
        end
        idx = 0;
        budget = 0;
        while (idx < n && budget < 400) begin
            r = toggle ? 1'($urandom_range(1)) : 1'b1;
            set_ready(r);
            vectors++;
            if (cur_valid() !== 1'b1 || cur_data() !== exp[idx] || cur_last() !== (idx == n - 1)) begin
                miscompares++;
                $display("FAIL %s read[%0d]: got v=%0b d=%010h l=%0b want v=1 d=%010h l=%0b",
                         name, idx, cur_valid(), cur_data(), cur_last(), exp[idx], idx == n - 1);
            end
            tick();
            if (r) idx++;
            budget++;
        end
        set_ready(1'b0);
        if (n == 0) tick();
        vectors++;
        if (idx < n) begin
            miscompares++;
            $display("FAIL %s drain_timeout: got %0d reads want %0d", name, idx, n);
        end
        vectors++;
        if (cur_state() !== 2'd0 || cur_valid() !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_drain: got state=%0d valid=%0b want state=0 valid=0",
                     name, cur_state(), cur_valid());
        end
        m_phase = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        {iv, taken, jalr, ret, trap, bkpt, ext, tpc_en, arm64, arm8} = '0;
        pc = '0; tpc = '0; mode = '0; filt = '0; post64 = '0; post8 = '0;
        if64.rd_ready = 1'b0;
        if8.rd_ready  = 1'b0;
        #1;
        vectors++;
        if ({st64, cnt64, wr64, if64.rd_valid, if64.rd_last} !== '0) begin
            miscompares++;
            $display("FAIL reset64: got st=%0d cnt=%0d wr=%0b v=%0b l=%0b want all 0",
                     st64, cnt64, wr64, if64.rd_valid, if64.rd_last);
        end
        vectors++;
        if ({st8, cnt8, wr8, if8.rd_valid, if8.rd_last} !== '0) begin
            miscompares++;
            $display("FAIL reset8: got st=%0d cnt=%0d wr=%0b v=%0b l=%0b want all 0",
                     st8, cnt8, wr8, if8.rd_valid, if8.rd_last);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        sel8 = 1'b0; m_depth = 64; filt = 2'd0; post64 = 7'd3;
        do_arm();
        vectors++;
        if (st64 !== 2'd1 || cnt64 !== 7'd0) begin
            miscompares++;
            $display("FAIL basic_armed: got st=%0d cnt=%0d want st=1 cnt=0", st64, cnt64);
        end
        for (int i = 0; i < 14; i++) retire(32'h100 + 32'(4 * i), i == 10, 1'b0, 1'b0);
        vectors++;
        if (cnt64 !== 7'd14 || wr64 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_count: got cnt=%0d wr=%0b want cnt=14 wr=0", cnt64, wr64);
        end
        drain("basic", 1'b0);
    endtask

    task automatic test_wrap();
        sel8 = 1'b1; m_depth = 8; filt = 2'd0; post8 = 4'd2; tpc = 32'h200; tpc_en = 1'b1;
        do_arm();
        for (int i = 0; i < 20; i++) retire(32'h200 - 32'd48 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        vectors++;
        if (cnt8 !== 4'd8 || wr8 !== 1'b1 || if8.rd_data[31:0] !== 32'h1EC) begin
            miscompares++;
            $display("FAIL wrap_first: got cnt=%0d wr=%0b pc=%08h want cnt=8 wr=1 pc=000001ec",
                     cnt8, wr8, if8.rd_data[31:0]);
        end
        drain("wrap", 1'b0);
        tpc_en = 1'b0; sel8 = 1'b0; m_depth = 64;
    endtask

    task automatic test_filter();
        int k;
        filt = 2'd1; post64 = 7'd4;
        do_arm();
        for (int i = 0; i < 12; i++) retire(rand_pc(), 1'b0, 1'b0, ($urandom_range(2) == 0));
        retire(32'h0000_4440, 1'b0, 1'b1, 1'b1);
        k = 0;
        while (m_phase == 2 && k < 60) begin
            retire(rand_pc(), 1'b0, 1'b0, ($urandom_range(2) == 0));
            k++;
        end
        drain("filter", 1'b0);
        filt = 2'd0;
    endtask

    task automatic test_post_limits();
        post64 = 7'd0;
        do_arm();
        retire(32'h0000_8000, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (st64 !== 2'd3 || cnt64 !== 7'd1) begin
            miscompares++;
            $display("FAIL post0: got st=%0d cnt=%0d want st=3 cnt=1", st64, cnt64);
        end
        drain("post0", 1'b0);
        post64 = 7'd127;
        do_arm();
        retire(32'h0000_9000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) retire(rand_pc(), 1'b0, 1'b0, 1'b0);
        vectors++;
        if (cnt64 !== 7'd64 || wr64 !== 1'b0 || if64.rd_data[31:0] !== 32'h9000) begin
            miscompares++;
            $display("FAIL post_clamp: got cnt=%0d wr=%0b pc=%08h want cnt=64 wr=0 pc=00009000",
                     cnt64, wr64, if64.rd_data[31:0]);
        end
        drain("post_clamp", 1'b0);
    endtask

    task automatic test_back_to_back();
        post64 = 7'd3;
        do_arm();
        for (int i = 0; i < 6; i++) retire(rand_pc(), i == 2, 1'b0, 1'b0);
        drain("backpressure", 1'b1);
    endtask

    task automatic test_arm_mid_readout();
        post64 = 7'd2;
        do_arm();
        for (int i = 0; i < 5; i++) retire(rand_pc(), i == 2, 1'b0, 1'b0);
        set_ready(1'b1);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (if64.rd_valid !== 1'b1 || if64.rd_data !== m_q[k]) begin
                miscompares++;
                $display("FAIL midread[%0d]: got v=%0b d=%010h want v=1 d=%010h",
                         k, if64.rd_valid, if64.rd_data, m_q[k]);
            end
            tick();
        end
        set_ready(1'b0);
        arm64 = 1'b1; iv = 1'b1; ext = 1'b1; pc = 32'h7000;
        tick();
        arm64 = 1'b0; iv = 1'b0; ext = 1'b0;
        vectors++;
        if (st64 !== 2'd1 || cnt64 !== 7'd0 || wr64 !== 1'b0 || if64.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rearm: got st=%0d cnt=%0d wr=%0b v=%0b want st=1 cnt=0 wr=0 v=0",
                     st64, cnt64, wr64, if64.rd_valid);
        end
        for (int i = 0; i < 5; i++) retire(rand_pc(), i == 2, 1'b0, 1'b0);
        drain("rearm", 1'b0);
    endtask

    task automatic test_reset_mid_post();
        post64 = 7'd10;
        do_arm();
        for (int i = 0; i < 6; i++) retire(rand_pc(), i == 3, 1'b0, 1'b0);
        vectors++;
        if (st64 !== 2'd2) begin
            miscompares++;
            $display("FAIL in_post: got st=%0d want 2", st64);
        end
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({st64, cnt64, wr64, if64.rd_valid, if64.rd_last} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got st=%0d cnt=%0d wr=%0b v=%0b l=%0b want all 0",
                     st64, cnt64, wr64, if64.rd_valid, if64.rd_last);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_q.delete();
        m_phase = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_filter();
        test_post_limits();
        test_back_to_back();
        test_arm_mid_readout();
        test_reset_mid_post();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
